// File: rtl/multi_cycle_pkg.sv
// Shared definitions for the multicycle MIPS controller: FSM states,
// opcodes, funct codes, ALUOp codes and ALU control codes.
package multi_cycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  // Instruction opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALUOp codes between controller and ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU control codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // True for every opcode the controller knows how to sequence
  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/AluDecoder.sv
// ALU decoder: maps ALUOp plus the funct field to the 3-bit ALU control.
module AluDecoder
  import multi_cycle_pkg::*;
(
  input  logic [5:0] funct,
  input  logic [1:0] aluOp,
  output logic [2:0] aluControl
);

  // Fixed add/sub for memory and branch ops, funct decode for R-type
  always_comb begin
    aluControl = ALU_ADD;
    case (aluOp)
      ALUOP_ADD: aluControl = ALU_ADD;
      ALUOP_SUB: aluControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  aluControl = ALU_ADD;
          FN_SUB:  aluControl = ALU_SUB;
          FN_AND:  aluControl = ALU_AND;
          FN_OR:   aluControl = ALU_OR;
          FN_SLT:  aluControl = ALU_SLT;
          default: aluControl = ALU_ADD;
        endcase
      end
      default: aluControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Multicycle MIPS controller: Moore FSM sequencing the shared datapath,
// with memory-ready handshaking in FETCH, MEMRD and MEMWR.
module multi_cycle_control
  import multi_cycle_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memReady,
  output logic       memRead,
  output logic       memWrite,
  output logic       iorD,
  output logic       irWrite,
  output logic       pcEn,
  output logic [1:0] pcSource,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [2:0] aluControl,
  output logic       regWrite,
  output logic       regDst,
  output logic       memToReg,
  output logic       badOp
);

  state_t     state_reg;
  state_t     state_next;
  logic [1:0] alu_op;
  logic       pc_write;
  logic       branch;
  logic       mem_read_raw;
  logic       mem_write_raw;
  logic       ir_write_raw;
  logic       reg_write_raw;
  logic       bad_op_raw;

  // State register; reset drops straight back to FETCH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; memReady only matters in the three memory states
  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH:   state_next = memReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXECUTE;
          OP_BEQ:       state_next = S_BEQEX;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JEX;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (Op == OP_LW)      state_next = S_MEMRD;
        else if (Op == OP_SW) state_next = S_MEMWR;
        else                  state_next = S_FETCH;
      end
      S_MEMRD:   state_next = memReady ? S_MEMWB : S_MEMRD;
      S_MEMWB:   state_next = S_FETCH;
      S_MEMWR:   state_next = memReady ? S_FETCH : S_MEMWR;
      S_EXECUTE: state_next = S_ALUWB;
      S_ALUWB:   state_next = S_FETCH;
      S_BEQEX:   state_next = S_FETCH;
      S_ADDIEX:  state_next = S_ADDIWB;
      S_ADDIWB:  state_next = S_FETCH;
      S_JEX:     state_next = S_FETCH;
      default:   state_next = S_FETCH;
    endcase
  end

  // Output decode; anything not set for a state stays 0
  always_comb begin
    mem_read_raw  = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    bad_op_raw    = 1'b0;
    pc_write      = 1'b0;
    branch        = 1'b0;
    iorD          = 1'b0;
    pcSource      = 2'b00;
    aluSrcA       = 1'b0;
    aluSrcB       = 2'b00;
    alu_op        = ALUOP_ADD;
    regDst        = 1'b0;
    memToReg      = 1'b0;
    case (state_reg)
      S_FETCH: begin
        mem_read_raw = 1'b1;
        aluSrcB      = 2'b01;
        ir_write_raw = memReady;
        pc_write     = memReady;
      end
      S_DECODE: begin
        aluSrcB    = 2'b11;
        bad_op_raw = !op_supported(Op);
      end
      S_MEMADR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
      end
      S_MEMRD: begin
        mem_read_raw = 1'b1;
        iorD         = 1'b1;
      end
      S_MEMWB: begin
        reg_write_raw = 1'b1;
        memToReg      = 1'b1;
      end
      S_MEMWR: begin
        mem_write_raw = 1'b1;
        iorD          = 1'b1;
      end
      S_EXECUTE: begin
        aluSrcA = 1'b1;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        regDst        = 1'b1;
      end
      S_BEQEX: begin
        aluSrcA  = 1'b1;
        alu_op   = ALUOP_SUB;
        branch   = 1'b1;
        pcSource = 2'b01;
      end
      S_ADDIEX: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
      end
      S_ADDIWB: begin
        reg_write_raw = 1'b1;
      end
      S_JEX: begin
        pc_write = 1'b1;
        pcSource = 2'b10;
      end
      default: begin
        aluSrcB = 2'b01;
      end
    endcase
  end

  // Enables and requests are masked while reset is held so an aborted
  // instruction can never complete a write during reset
  assign memRead  = mem_read_raw  & ~reset;
  assign memWrite = mem_write_raw & ~reset;
  assign irWrite  = ir_write_raw  & ~reset;
  assign regWrite = reg_write_raw & ~reset;
  assign badOp    = bad_op_raw    & ~reset;
  assign pcEn     = (pc_write | (branch & zero)) & ~reset;

  AluDecoder u_alu_decoder (
    .funct      (funct),
    .aluOp      (alu_op),
    .aluControl (aluControl)
  );

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control: each cycle compares the full
// output vector against a hand-written expected vector.
module tb_multi_cycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Op;
  logic [5:0] funct;
  logic       zero;
  logic       memReady;
  logic       memRead, memWrite, iorD, irWrite, pcEn;
  logic [1:0] pcSource;
  logic       aluSrcA;
  logic [1:0] aluSrcB;
  logic [2:0] aluControl;
  logic       regWrite, regDst, memToReg, badOp;

  int checks = 0;
  int errors = 0;

  multi_cycle_control dut (
    .clk        (clk),
    .reset      (reset),
    .Op         (Op),
    .funct      (funct),
    .zero       (zero),
    .memReady   (memReady),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .iorD       (iorD),
    .irWrite    (irWrite),
    .pcEn       (pcEn),
    .pcSource   (pcSource),
    .aluSrcA    (aluSrcA),
    .aluSrcB    (aluSrcB),
    .aluControl (aluControl),
    .regWrite   (regWrite),
    .regDst     (regDst),
    .memToReg   (memToReg),
    .badOp      (badOp)
  );

  always #5 clk = ~clk;

  // Packed view of all outputs:
  // memRead memWrite iorD irWrite pcEn pcSource aluSrcA aluSrcB aluControl regWrite regDst memToReg badOp
  logic [16:0] obs;
  assign obs = {memRead, memWrite, iorD, irWrite, pcEn, pcSource, aluSrcA,
                aluSrcB, aluControl, regWrite, regDst, memToReg, badOp};

  localparam logic [16:0] E_RESET      = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b01,3'b010,1'b0,1'b0,1'b0,1'b0};
  localparam logic [16:0] E_FETCH      = {1'b1,1'b0,1'b0,1'b1,1'b1,2'b00,1'b0,2'b01,3'b010,1'b0,1'b0,1'b0,1'b0};
  localparam logic [16:0] E_FETCH_WAIT = {1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b01,3'b010,1'b0,1'b0,1'b0,1'b0};
  localparam logic [16:0] E_DECODE     = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b11,3'b010,1'b0,1'b0,1'b0,1'b0};
  localparam logic [16:0] E_DECODE_BAD = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b11,3'b010,1'b0,1'b0,1'b0,1'b1};
  localparam logic [16:0] E_MEMADR     = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b10,3'b010,1'b0,1'b0,1'b0,1'b0};
  localparam logic [16:0] E_MEMRD      = {1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,3'b010,1'b0,1'b0,1'b0,1'b0};
  localparam logic [16:0] E_MEMWB      = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,3'b010,1'b1,1'b0,1'b1,1'b0};
  localparam logic [16:0] E_MEMWR      = {1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,3'b010,1'b0,1'b0,1'b0,1'b0};
  localparam logic [16:0] E_ALUWB      = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,3'b010,1'b1,1'b1,1'b0,1'b0};
  localparam logic [16:0] E_BEQ_TAKEN  = {1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,1'b1,2'b00,3'b110,1'b0,1'b0,1'b0,1'b0};
  localparam logic [16:0] E_BEQ_NOT    = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,1'b1,2'b00,3'b110,1'b0,1'b0,1'b0,1'b0};
  localparam logic [16:0] E_ADDIEX     = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b10,3'b010,1'b0,1'b0,1'b0,1'b0};
  localparam logic [16:0] E_ADDIWB     = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,3'b010,1'b1,1'b0,1'b0,1'b0};
  localparam logic [16:0] E_JEX        = {1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,2'b00,3'b010,1'b0,1'b0,1'b0,1'b0};

  // R-type funct table with hand-derived ALU control
  localparam int N_FN = 6;
  logic [5:0] fn_tab  [N_FN] = '{6'b101010, 6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b000111};
  logic [2:0] ctl_tab [N_FN] = '{3'b111,    3'b010,    3'b110,    3'b000,    3'b001,    3'b010};

  task automatic check_eq(input string tag, input logic [16:0] got, input logic [16:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // One controller cycle: drive inputs just after the rising edge,
  // compare on the falling edge, then advance to the next rising edge.
  task automatic cyc(input logic mr, input logic z, input string tag, input logic [16:0] exp);
    memReady = mr;
    zero     = z;
    @(negedge clk);
    check_eq(tag, obs, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    Op       = 6'b000000;
    funct    = 6'b000000;
    zero     = 1'b0;
    memReady = 1'b0;
    #2;
    check_eq("rst_init", obs, E_RESET);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // lw with one memory wait in FETCH and one in MEMRD
    Op = 6'b100011;
    cyc(1'b0, 1'b0, "lw_fetch_wait", E_FETCH_WAIT);
    cyc(1'b1, 1'b0, "lw_fetch", E_FETCH);
    cyc(1'b0, 1'b0, "lw_decode", E_DECODE);
    cyc(1'b0, 1'b0, "lw_memadr", E_MEMADR);
    cyc(1'b0, 1'b0, "lw_memrd_wait", E_MEMRD);
    cyc(1'b1, 1'b0, "lw_memrd", E_MEMRD);
    cyc(1'b1, 1'b0, "lw_memwb", E_MEMWB);
    $display("instr lw with waits done");

    // lw, memReady tied high: 5 cycles
    cyc(1'b1, 1'b0, "lw2_fetch", E_FETCH);
    cyc(1'b1, 1'b0, "lw2_decode", E_DECODE);
    cyc(1'b1, 1'b0, "lw2_memadr", E_MEMADR);
    cyc(1'b1, 1'b0, "lw2_memrd", E_MEMRD);
    cyc(1'b1, 1'b0, "lw2_memwb", E_MEMWB);
    $display("instr lw done");

    // sw with memReady low three cycles in MEMWR
    Op = 6'b101011;
    cyc(1'b1, 1'b0, "sw_fetch", E_FETCH);
    cyc(1'b1, 1'b0, "sw_decode", E_DECODE);
    cyc(1'b1, 1'b0, "sw_memadr", E_MEMADR);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, $sformatf("sw_memwr_wait%0d", i), E_MEMWR);
    cyc(1'b1, 1'b0, "sw_memwr", E_MEMWR);
    $display("instr sw with waits done");

    // beq taken
    Op = 6'b000100;
    cyc(1'b1, 1'b0, "beq1_fetch", E_FETCH);
    cyc(1'b1, 1'b0, "beq1_decode", E_DECODE);
    cyc(1'b1, 1'b1, "beq1_taken", E_BEQ_TAKEN);
    $display("instr beq taken done");

    // beq not taken
    cyc(1'b1, 1'b0, "beq0_fetch", E_FETCH);
    cyc(1'b1, 1'b0, "beq0_decode", E_DECODE);
    cyc(1'b1, 1'b0, "beq0_not_taken", E_BEQ_NOT);
    $display("instr beq not taken done");

    // R-type over the funct table
    Op = 6'b000000;
    for (int i = 0; i < N_FN; i++) begin
      funct = fn_tab[i];
      cyc(1'b1, 1'b0, $sformatf("r%0d_fetch", i), E_FETCH);
      cyc(1'b1, 1'b0, $sformatf("r%0d_decode", i), E_DECODE);
      cyc(1'b1, 1'b0, $sformatf("r%0d_execute", i),
          {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b00,ctl_tab[i],1'b0,1'b0,1'b0,1'b0});
      cyc(1'b1, 1'b0, $sformatf("r%0d_aluwb", i), E_ALUWB);
      $display("instr rtype funct=%b done", fn_tab[i]);
    end
    funct = 6'b000000;

    // addi
    Op = 6'b001000;
    cyc(1'b1, 1'b0, "addi_fetch", E_FETCH);
    cyc(1'b1, 1'b0, "addi_decode", E_DECODE);
    cyc(1'b1, 1'b0, "addi_ex", E_ADDIEX);
    cyc(1'b1, 1'b0, "addi_wb", E_ADDIWB);
    $display("instr addi done");

    // j
    Op = 6'b000010;
    cyc(1'b1, 1'b0, "j_fetch", E_FETCH);
    cyc(1'b1, 1'b0, "j_decode", E_DECODE);
    cyc(1'b1, 1'b0, "j_ex", E_JEX);
    $display("instr j done");

    // unsupported opcode
    Op = 6'b111111;
    cyc(1'b1, 1'b0, "bad_fetch", E_FETCH);
    cyc(1'b1, 1'b0, "bad_decode", E_DECODE_BAD);
    cyc(1'b0, 1'b0, "bad_after_fetch", E_FETCH_WAIT);
    $display("instr badop done");

    // reset asserted in the middle of MEMWB
    Op = 6'b100011;
    cyc(1'b1, 1'b0, "rlw_fetch", E_FETCH);
    cyc(1'b1, 1'b0, "rlw_decode", E_DECODE);
    cyc(1'b1, 1'b0, "rlw_memadr", E_MEMADR);
    cyc(1'b1, 1'b0, "rlw_memrd", E_MEMRD);
    check_eq("rlw_memwb_pre", obs, E_MEMWB);
    reset = 1'b1;
    #1;
    check_eq("rst_mid_memwb", obs, E_RESET);
    @(posedge clk);
    #1;
    check_eq("rst_held", obs, E_RESET);
    memReady = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    cyc(1'b0, 1'b0, "post_rst_fetch", E_FETCH_WAIT);
    cyc(1'b1, 1'b0, "post_rst_fetch_go", E_FETCH);
    cyc(1'b1, 1'b0, "post_rst_decode", E_DECODE);
    $display("instr reset abort done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_cycle_control.md
# multi_cycle_control

Multicycle MIPS controller: a Moore state machine that sequences the shared datapath (one memory, one ALU, register file) across several cycles per instruction. It replaces the single-cycle control path when the core moves to the multicycle datapath, and adds a ready handshake so instruction/data memory may take more than one cycle. It drives every datapath mux and write enable and generates the 3-bit ALU control.

## Interface

- No parameters; opcodes, states and ALUOp codes live in the shared package.
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; forces state to FETCH
- Op  input  6  opcode field from the instruction register
- funct  input  6  funct field from the instruction register
- zero  input  1  ALU zero flag
- memReady  input  1  memory completed the current access this cycle
- memRead  output  1  memory read request
- memWrite  output  1  memory write request
- iorD  output  1  memory address select: 0 = PC, 1 = ALUOut
- irWrite  output  1  instruction register load
- pcEn  output  1  PC load enable = pcWrite | (branch & zero)
- pcSource  output  2  PC mux: 00 ALU result, 01 ALUOut, 10 jump target
- aluSrcA  output  1  0 = PC, 1 = register A
- aluSrcB  output  2  00 B, 01 constant 4, 10 sign-extended imm, 11 imm << 2
- aluControl  output  3  ALU operation
- regWrite  output  1  register file write
- regDst  output  1  0 = rt, 1 = rd
- memToReg  output  1  0 = ALUOut, 1 = memory data register
- badOp  output  1  unsupported opcode seen in DECODE

## Operation

- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BEQEX, ADDIEX, ADDIWB, JEX.
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- FETCH: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, ALUOp add, pcSource=00; irWrite=pcWrite=memReady. Stays while memReady=0; -> DECODE when memReady=1.
- DECODE: aluSrcA=0, aluSrcB=11, ALUOp add (branch target precompute). Next: lw/sw -> MEMADR, R-type -> EXECUTE, beq -> BEQEX, addi -> ADDIEX, j -> JEX, other -> FETCH with badOp=1 this cycle.
- MEMADR: aluSrcA=1, aluSrcB=10, ALUOp add; lw -> MEMRD, sw -> MEMWR.
- MEMRD: memRead=1, iorD=1; holds until memReady, then -> MEMWB.
- MEMWB: regWrite=1, regDst=0, memToReg=1 -> FETCH.
- MEMWR: memWrite=1, iorD=1; holds until memReady, then -> FETCH.
- EXECUTE: aluSrcA=1, aluSrcB=00, ALUOp funct -> ALUWB. ALUWB: regWrite=1, regDst=1, memToReg=0 -> FETCH.
- BEQEX: aluSrcA=1, aluSrcB=00, ALUOp sub, branch=1, pcSource=01 -> FETCH.
- ADDIEX: aluSrcA=1, aluSrcB=10, ALUOp add -> ADDIWB. ADDIWB: regWrite=1, regDst=0, memToReg=0 -> FETCH.
- JEX: pcWrite=1, pcSource=10 -> FETCH.
- ALUOp: 00 add, 01 sub, 10 decode funct; aluControl from ALUOp/funct (add 010, sub 110, and 000, or 001, slt 111; unknown funct -> 010).
- Signals not listed for a state are 0 (don't-cares driven 0).

## Timing

- State register updates on rising clk; all outputs are combinational from state, plus memReady (FETCH) and zero (pcEn in BEQEX).
- Reset asserted: state = FETCH immediately; irWrite, pcEn, regWrite, memWrite, memRead, badOp forced 0 for the duration of reset. Mux selects show FETCH values.
- Reset mid-instruction aborts it; no partial write completes after reset assertion.
- Cycles per instruction with memReady tied 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each memory wait cycle adds 1.
- memRead/memWrite and iorD are held constant while waiting; the request drops the cycle after memReady.
- memReady outside FETCH/MEMRD/MEMWR is ignored.

## Structure

- Package multi_cycle_pkg: state enum (4-bit), opcode localparams, ALUOp codes, aluControl codes.
- One sub-module: existing AluDecoder (funct + ALUOp -> aluControl), instantiated unchanged.
- Controller body: state register, next-state logic, output decode.

## Test plan

- Reset asserted mid-MEMWB -> state FETCH, regWrite=0 the same cycle; after release, memRead=1, iorD=0.
- lw (Op=100011), memReady=1 -> state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; regWrite=1, memToReg=1 only in MEMWB.
- sw with memReady low 3 cycles in MEMWR -> memWrite=1, iorD=1 held 4 cycles, then FETCH; regWrite never 1.
- beq with zero=1 -> pcEn=1, pcSource=01 in BEQEX; zero=0 -> pcEn=0; 3 cycles total.
- R-type funct=101010 -> aluControl=111 in EXECUTE, regWrite=1 with regDst=1 in ALUWB.
- Op=111111 -> badOp=1 in DECODE, next state FETCH, no write enable asserted.
